// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: serialises NCH strobe/ready requesters onto one shared memory port
module mem_port_arbiter #(
    parameter int NCH = 2,
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NCH-1:0]    req_init,
    input  logic [3*NCH-1:0]  req_read_op,
    input  logic [2*NCH-1:0]  req_write_op,
    input  logic [AW*NCH-1:0] req_addr,
    input  logic [DW*NCH-1:0] req_wdata,
    output logic [NCH-1:0]    req_ready,
    output logic [DW-1:0]     req_rdata,
    output logic              mem_init,
    output logic [2:0]        mem_read_op,
    output logic [1:0]        mem_write_op,
    output logic [AW-1:0]     mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic              mem_ready,
    input  logic [DW-1:0]     mem_rdata,
    output logic [NCH-1:0]    grant,
    output logic              err
);
    localparam int IW = $clog2(NCH);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
    state_t state, state_nx;
    logic [NCH-1:0] pending;
    logic [2:0] slot_rop [NCH];
    logic [1:0] slot_wop [NCH];
    logic [AW-1:0] slot_addr [NCH];
    logic [DW-1:0] slot_wdata [NCH];
    logic [IW-1:0] rr, gidx, win;
    logic found, done;
    int idx;
    assign done = state != IDLE && mem_ready;
    assign mem_init = state == ISSUE;
    always_comb begin
        win = '0;
        found = 1'b0;
        idx = 0;
        for (int k = 0; k < NCH; k++) begin
            idx = (FIXED_PRIO != 0 ? 0 : int'(rr)) + k;
            idx = idx >= NCH ? idx - NCH : idx;
            if (!found && pending[idx]) begin
                found = 1'b1;
                win = IW'(idx);
            end
        end
    end
    always_comb state_nx = done ? IDLE : state == IDLE ? (found ? ISSUE : IDLE) : WAIT;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            pending <= '0;
            rr <= '0;
            gidx <= '0;
            req_ready <= '0;
            req_rdata <= '0;
            mem_read_op <= '0;
            mem_write_op <= '0;
            mem_addr <= '0;
            mem_wdata <= '0;
            grant <= '0;
            err <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                slot_rop[i] <= '0;
                slot_wop[i] <= '0;
                slot_addr[i] <= '0;
                slot_wdata[i] <= '0;
            end
        end else begin
            state <= state_nx;
            req_ready <= '0;
            if (state == IDLE && found) begin
                grant <= NCH'(1) << win;
                gidx <= win;
                mem_read_op <= slot_rop[win];
                mem_write_op <= slot_wop[win];
                mem_addr <= slot_addr[win];
                mem_wdata <= slot_wdata[win];
            end
            if (done) begin
                req_rdata <= mem_rdata;
                req_ready[gidx] <= 1'b1;
                pending[gidx] <= 1'b0;
                rr <= gidx == IW'(NCH - 1) ? '0 : gidx + 1'b1;
                grant <= '0;
            end
            // a strobe landing on the completing channel re-arms it rather than erroring
            for (int i = 0; i < NCH; i++) begin
                if (req_init[i] && pending[i] && !(done && gidx == IW'(i))) begin
                    err <= 1'b1;
                end else if (req_init[i]) begin
                    pending[i] <= 1'b1;
                    slot_rop[i] <= req_read_op[3*i +: 3];
                    slot_wop[i] <= req_write_op[2*i +: 2];
                    slot_addr[i] <= req_addr[AW*i +: AW];
                    slot_wdata[i] <= req_wdata[DW*i +: DW];
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: vector table, directed corner cases and a randomized run against a transaction-level model
module tb_mem_port_arbiter;
    localparam int N = 2;
    logic clk = 0, reset = 0;
    always #5 clk = ~clk;
    logic [N-1:0] req_init, req_ready, grant;
    logic [3*N-1:0] req_read_op;
    logic [2*N-1:0] req_write_op;
    logic [32*N-1:0] req_addr, req_wdata;
    logic [31:0] req_rdata, mem_addr, mem_wdata, mem_rdata;
    logic [2:0] mem_read_op;
    logic [1:0] mem_write_op;
    logic mem_init, mem_ready, err;
    logic [2:0] f_req_init, f_req_ready, f_grant, f_mem_read_op;
    logic [8:0] f_req_read_op;
    logic [5:0] f_req_write_op;
    logic [95:0] f_req_addr, f_req_wdata;
    logic [31:0] f_req_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata;
    logic [1:0] f_mem_write_op;
    logic f_mem_init, f_mem_ready, f_err;
    mem_port_arbiter #(.NCH(N), .AW(32), .DW(32), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset), .req_init(req_init), .req_read_op(req_read_op),
        .req_write_op(req_write_op), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .req_rdata(req_rdata), .mem_init(mem_init),
        .mem_read_op(mem_read_op), .mem_write_op(mem_write_op), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
        .grant(grant), .err(err));
    mem_port_arbiter #(.NCH(3), .AW(32), .DW(32), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(reset), .req_init(f_req_init), .req_read_op(f_req_read_op),
        .req_write_op(f_req_write_op), .req_addr(f_req_addr), .req_wdata(f_req_wdata),
        .req_ready(f_req_ready), .req_rdata(f_req_rdata), .mem_init(f_mem_init),
        .mem_read_op(f_mem_read_op), .mem_write_op(f_mem_write_op), .mem_addr(f_mem_addr),
        .mem_wdata(f_mem_wdata), .mem_ready(f_mem_ready), .mem_rdata(f_mem_rdata),
        .grant(f_grant), .err(f_err));
    typedef struct {
        int ch;
        logic [2:0] rop;
        logic [1:0] wop;
        logic [31:0] addr, wdata, rdata;
        int dly;
        logic [1:0] exp_grant;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vt [4];
    int total = 0, bad = 0;
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step();
        @(negedge clk);
        req_init = '0;
        mem_ready = 0;
        f_req_init = '0;
        f_mem_ready = 0;
    endtask
    task automatic drive(input int c, input logic [2:0] rop, input logic [1:0] wop, input logic [31:0] a, input logic [31:0] d);
        req_init[c] = 1;
        req_read_op[3*c +: 3] = rop;
        req_write_op[2*c +: 2] = wop;
        req_addr[32*c +: 32] = a;
        req_wdata[32*c +: 32] = d;
    endtask
    task automatic fdrive(input int c, input logic [31:0] a);
        f_req_init[c] = 1;
        f_req_read_op[3*c +: 3] = 3'd2;
        f_req_write_op[2*c +: 2] = 2'd0;
        f_req_addr[32*c +: 32] = a;
        f_req_wdata[32*c +: 32] = 32'h0;
    endtask
    task automatic do_reset();
        reset = 0;
        step();
        step();
        reset = 1;
        step();
    endtask
    task automatic wait_init(input string name, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!mem_init && n < 20);
        chk({name, "_mem_init"}, mem_init, 1);
    endtask
    task automatic complete(input int c, input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd, input int dly);
        for (int i = 0; i < dly; i++) begin
            step();
            chk("hold_addr", mem_addr, a);
            chk("hold_wdata", mem_wdata, wd);
            chk("init_one_cycle", mem_init, 0);
        end
        mem_ready = 1;
        mem_rdata = rd;
        step();
        chk("req_ready", req_ready, 64'(1) << c);
        chk("req_rdata", req_rdata, rd);
        chk("grant_released", grant, 0);
    endtask
    task automatic serve(input int c, input logic [31:0] a, input logic [31:0] rd, input int dly, output int n);
        wait_init("serve", n);
        chk("serve_grant", grant, 64'(1) << c);
        chk("serve_addr", mem_addr, a);
        complete(c, a, 0, rd, dly);
    endtask
    int n, fn;
    int outst [N], gnt [N], scyc [N];
    logic [2:0] r_rop [N];
    logic [1:0] r_wop [N];
    logic [31:0] r_addr [N], r_wd [N];
    int infl, cnt, rrm, ech, cyc, w;
    logic [31:0] erd;
    initial begin
        req_init = '0; req_read_op = '0; req_write_op = '0; req_addr = '0; req_wdata = '0;
        mem_ready = 0; mem_rdata = 32'hA5A5A5A5;
        f_req_init = '0; f_req_read_op = '0; f_req_write_op = '0; f_req_addr = '0; f_req_wdata = '0;
        f_mem_ready = 0; f_mem_rdata = '0;
        vt[0] = '{0, 3'd2, 2'd0, 32'h100, 32'h0, 32'hDEADBEEF, 2, 2'b01, 32'hDEADBEEF};
        vt[1] = '{1, 3'd0, 2'd3, 32'h40, 32'h12345678, 32'h0BAD0BAD, 0, 2'b10, 32'h0BAD0BAD};
        vt[2] = '{1, 3'd5, 2'd0, 32'hFFFFFFFC, 32'h0, 32'h55AA55AA, 3, 2'b10, 32'h55AA55AA};
        vt[3] = '{0, 3'd1, 2'd1, 32'h0, 32'hFFFFFFFF, 32'h00000000, 1, 2'b01, 32'h00000000};
        step();
        step();
        chk("rst_grant", grant, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_mem_fields", {mem_init, mem_read_op, mem_write_op, mem_addr, mem_wdata}, 0);
        chk("rst_rdata_err", {req_rdata, err}, 0);
        reset = 1;
        mem_ready = 1;
        step();
        step();
        chk("idle_ready_ignored", {req_ready, mem_init, grant}, 0);
        for (int v = 0; v < 4; v++) begin
            drive(vt[v].ch, vt[v].rop, vt[v].wop, vt[v].addr, vt[v].wdata);
            wait_init("vec", n);
            chk("vec_latency", n, 2);
            chk("vec_grant", grant, vt[v].exp_grant);
            chk("vec_ops", {mem_read_op, mem_write_op}, {vt[v].rop, vt[v].wop});
            chk("vec_addr", mem_addr, vt[v].addr);
            chk("vec_wdata", mem_wdata, vt[v].wdata);
            complete(vt[v].ch, vt[v].addr, vt[v].wdata, vt[v].rdata, vt[v].dly);
            chk("vec_ready_ch", req_ready, vt[v].exp_grant);
            chk("vec_rdata", req_rdata, vt[v].exp_rdata);
            step();
            chk("vec_ready_pulse", req_ready, 0);
        end
        chk("vec_no_err", err, 0);
        do_reset();
        for (int r = 0; r < 3; r++) begin
            drive(0, 3'd2, 2'd0, 32'h1000 + r, 32'h0);
            drive(1, 3'd2, 2'd0, 32'h2000 + r, 32'h0);
            serve(0, 32'h1000 + r, 32'h100 + r, 1, n);
            serve(1, 32'h2000 + r, 32'h200 + r, 1, n);
            chk("rr_b2b_gap", n, 1);
        end
        drive(1, 3'd0, 2'd3, 32'h40, 32'h12345678);
        step();
        drive(1, 3'd2, 2'd0, 32'h80, 32'hCAFEF00D);
        wait_init("dup", n);
        chk("dup_fields", {mem_addr, mem_wdata, mem_write_op}, {32'h40, 32'h12345678, 2'd3});
        complete(1, 32'h40, 32'h12345678, 32'h1, 3);
        chk("dup_err", err, 1);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("dup_single_ready", {req_ready, mem_init}, 0);
        end
        drive(0, 3'd2, 2'd0, 32'h200, 32'h0);
        wait_init("rst_mid", n);
        step();
        reset = 0;
        #1;
        chk("rst_mid_outs", {mem_init, mem_read_op, mem_write_op, mem_addr, mem_wdata}, 0);
        chk("rst_mid_ctl", {grant, req_ready, err, req_rdata}, 0);
        step();
        reset = 1;
        step();
        mem_ready = 1;
        mem_rdata = 32'h77;
        step();
        chk("rst_stale_ready", {req_ready, grant, mem_init}, 0);
        step();
        chk("rst_stale_after", {req_ready, grant, mem_init}, 0);
        drive(0, 3'd2, 2'd0, 32'h300, 32'h0);
        serve(0, 32'h300, 32'h3333, 1, n);
        chk("rst_recover_latency", n, 2);
        drive(0, 3'd2, 2'd0, 32'h400, 32'h0);
        serve(0, 32'h400, 32'h4444, 0, n);
        drive(0, 3'd1, 2'd0, 32'h404, 32'h0);
        wait_init("restrobe", n);
        chk("restrobe_latency", n, 2);
        chk("restrobe_fields", {grant, mem_addr, mem_read_op}, {2'b01, 32'h404, 3'd1});
        chk("restrobe_err", err, 0);
        complete(0, 32'h404, 0, 32'h5555, 1);
        fdrive(0, 32'hA00);
        fdrive(2, 32'hC00);
        for (int k = 0; k < 4; k++) begin
            fn = 0;
            do begin step(); fn++; end while (!f_mem_init && fn < 20);
            chk("fp_init", f_mem_init, 1);
            chk("fp_grant_ch0", f_grant, 3'b001);
            chk("fp_addr", f_mem_addr, 32'hA00 + k);
            step();
            f_mem_ready = 1;
            if (k < 3) fdrive(0, 32'hA00 + k + 1);
            step();
            chk("fp_ready_ch0", f_req_ready, 3'b001);
        end
        fn = 0;
        do begin step(); fn++; end while (!f_mem_init && fn < 20);
        chk("fp_ch2_grant", {f_mem_init, f_grant, f_mem_addr}, {1'b1, 3'b100, 32'hC00});
        f_mem_ready = 1;
        step();
        chk("fp_ch2_ready", f_req_ready, 3'b100);
        chk("fp_no_err", f_err, 0);
        do_reset();
        infl = -1; cnt = 0; rrm = 0; ech = -1; cyc = 0;
        for (int c = 0; c < N; c++) begin outst[c] = 0; gnt[c] = 0; scyc[c] = 0; end
        for (int t = 0; t < 3000; t++) begin
            step();
            cyc++;
            mem_rdata = $urandom;
            if (ech >= 0) begin
                chk("rnd_ready", req_ready, 64'(1) << ech);
                chk("rnd_rdata", req_rdata, erd);
                outst[ech] = 0;
                ech = -1;
            end else chk("rnd_no_ready", req_ready, 0);
            if (mem_init) begin
                chk("rnd_no_overlap", infl < 0, 1);
                w = -1;
                for (int k = 0; k < N; k++) begin
                    int c;
                    c = (rrm + k) % N;
                    if (w < 0 && outst[c] != 0 && gnt[c] == 0 && scyc[c] <= cyc - 2) w = c;
                end
                if (w < 0) chk("rnd_spurious_init", mem_init, 0);
                else begin
                    chk("rnd_grant", grant, 64'(1) << w);
                    chk("rnd_fields", {mem_read_op, mem_write_op, mem_addr, mem_wdata}, {r_rop[w], r_wop[w], r_addr[w], r_wd[w]});
                    infl = w;
                    gnt[w] = 1;
                    rrm = (w + 1) % N;
                    cnt = $urandom_range(0, 3);
                end
            end else if (infl >= 0) chk("rnd_hold", {mem_addr, mem_wdata}, {r_addr[infl], r_wd[infl]});
            if (infl >= 0) begin
                if (cnt == 0) begin
                    mem_ready = 1;
                    ech = infl;
                    erd = mem_rdata;
                    infl = -1;
                end else cnt--;
            end else if ($urandom_range(0, 3) == 0) mem_ready = 1;
            for (int c = 0; c < N; c++) begin
                if (outst[c] == 0 && t < 2900 && $urandom_range(0, 2) == 0) begin
                    r_rop[c] = 3'($urandom);
                    r_wop[c] = 2'($urandom);
                    r_addr[c] = $urandom;
                    r_wd[c] = $urandom;
                    drive(c, r_rop[c], r_wop[c], r_addr[c], r_wd[c]);
                    outst[c] = 1;
                    gnt[c] = 0;
                    scyc[c] = cyc;
                end
            end
        end
        chk("rnd_drained", outst[0] + outst[1], 0);
        chk("rnd_no_err", err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
